// File: rtl/ip_call_stack_sequencer.sv
// ----------------------------------------------------------------------------
// ip_call_stack_sequencer
//
// Instruction-pointer unit with a hardware return-address stack. It takes
// branch/call/return strobes from execute-stage decode and produces the
// instruction ROM fetch address. The fetch address is combinational, so a
// redirect reaches the ROM in the same cycle it is decoded.
//
// Optional feature macro: IPSEQ_TRAP_EN
//   undefined : CALL while full overwrites the oldest entry (circular).
//               RET while empty returns to RESET_ADDR. The fault flags are
//               tied low and iClearFlags is ignored.
//   defined   : CALL while full or RET while empty redirects to TRAP_ADDR.
//               The stack is left untouched and a sticky fault flag is set.
//
// Ports
//   Clock       in   rising-edge clock for all state
//   Reset       in   synchronous active-low reset
//   iEnable     in   advance IP; when low all other controls are ignored
//   iBranch     in   taken branch, redirect to iTarget
//   iCall       in   push return address, redirect to iTarget
//   iRet        in   pop, redirect to popped address
//   iTarget     in   branch/call destination (ADDR_W)
//   iClearFlags in   clear sticky fault flags
//   oIP         out  ROM fetch address, combinational (ADDR_W)
//   oDepth      out  number of valid stack entries
//   oFull       out  oDepth == DEPTH
//   oEmpty      out  oDepth == 0
//   oOverflow   out  sticky: CALL issued while full
//   oUnderflow  out  sticky: RET issued while empty
// ----------------------------------------------------------------------------
module ip_call_stack_sequencer #(
  parameter int                 ADDR_W     = 16,
  parameter int                 DEPTH      = 8,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0]  TRAP_ADDR  = 16'hFFF0
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       iEnable,
  input  logic                       iBranch,
  input  logic                       iCall,
  input  logic                       iRet,
  input  logic [ADDR_W-1:0]          iTarget,
  input  logic                       iClearFlags,
  output logic [ADDR_W-1:0]          oIP,
  output logic [$clog2(DEPTH+1)-1:0] oDepth,
  output logic                       oFull,
  output logic                       oEmpty,
  output logic                       oOverflow,
  output logic                       oUnderflow
);

  localparam int SP_W = $clog2(DEPTH);
  localparam int D_W  = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] stack_mem [DEPTH];
  logic [SP_W-1:0]   sp_reg;
  logic [D_W-1:0]    depth_reg;

  logic              is_full;
  logic              is_empty;
  logic [ADDR_W-1:0] top_addr;
  logic              take_ret;
  logic              take_call;
  logic              take_branch;
  logic              push_en;
  logic              pop_en;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] ip;

  assign is_full  = (depth_reg == D_W'(DEPTH));
  assign is_empty = (depth_reg == '0);

  // Top of stack sits one below the next-free pointer. Reading the
  // registered array directly lets a RET right after a CALL see the new entry.
  assign top_addr = stack_mem[sp_reg - SP_W'(1)];

  // Priority RET > CALL > BRANCH; losing strobes have no effect at all.
  assign take_ret    = iEnable & iRet;
  assign take_call   = iEnable & iCall & ~iRet;
  assign take_branch = iEnable & iBranch & ~iRet & ~iCall;

`ifdef IPSEQ_TRAP_EN
  logic fault_ovf;
  logic fault_unf;
  logic ovf_reg;
  logic unf_reg;

  assign fault_ovf = take_call & is_full;
  assign fault_unf = take_ret & is_empty;
  assign push_en   = take_call & ~is_full;
  assign pop_en    = take_ret & ~is_empty;

  always_comb begin
    redirect_addr = pc_reg;
    if (take_ret)
      redirect_addr = is_empty ? TRAP_ADDR : top_addr;
    else if (take_call)
      redirect_addr = is_full ? TRAP_ADDR : iTarget;
    else if (take_branch)
      redirect_addr = iTarget;
  end

  // A fault in the same cycle as a clear keeps the flag set.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      if (fault_ovf)
        ovf_reg <= 1'b1;
      else if (iEnable && iClearFlags)
        ovf_reg <= 1'b0;
      if (fault_unf)
        unf_reg <= 1'b1;
      else if (iEnable && iClearFlags)
        unf_reg <= 1'b0;
    end
  end

  assign oOverflow  = ovf_reg;
  assign oUnderflow = unf_reg;
`else
  logic unused_clear_flags;

  // A push while full lands on the oldest slot because sp_reg has wrapped
  // back onto it, giving circular overwrite.
  assign push_en = take_call;
  assign pop_en  = take_ret & ~is_empty;

  always_comb begin
    redirect_addr = pc_reg;
    if (take_ret)
      redirect_addr = is_empty ? RESET_ADDR : top_addr;
    else if (take_call || take_branch)
      redirect_addr = iTarget;
  end

  assign unused_clear_flags = iClearFlags;
  assign oOverflow  = 1'b0;
  assign oUnderflow = 1'b0;
`endif

  assign ip = !Reset ? RESET_ADDR : redirect_addr;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc_reg    <= RESET_ADDR + ADDR_W'(1);
      sp_reg    <= '0;
      depth_reg <= '0;
    end else if (iEnable) begin
      pc_reg <= ip + ADDR_W'(1);
      if (push_en) begin
        sp_reg <= sp_reg + SP_W'(1);
        if (!is_full)
          depth_reg <= depth_reg + D_W'(1);
      end else if (pop_en) begin
        sp_reg    <= sp_reg - SP_W'(1);
        depth_reg <= depth_reg - D_W'(1);
      end
    end
  end

  // Stack storage has no reset; the pointer and depth define validity.
  // The push value is pc_reg, the slot after the CALL's own fetch slot.
  always_ff @(posedge Clock) begin
    if (Reset && push_en)
      stack_mem[sp_reg] <= pc_reg;
  end

  assign oIP    = ip;
  assign oDepth = depth_reg;
  assign oFull  = is_full;
  assign oEmpty = is_empty;

endmodule

// File: tb/tb_ip_call_stack_sequencer.sv
module tb_ip_call_stack_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iEnable = 1'b0;
  logic        iBranch = 1'b0;
  logic        iCall = 1'b0;
  logic        iRet = 1'b0;
  logic [15:0] iTarget = '0;
  logic        iClearFlags = 1'b0;
  logic [15:0] oIP;
  logic [3:0]  oDepth;
  logic        oFull;
  logic        oEmpty;
  logic        oOverflow;
  logic        oUnderflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] pushes [9];

  ip_call_stack_sequencer dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iBranch(iBranch),
    .iCall(iCall), .iRet(iRet), .iTarget(iTarget), .iClearFlags(iClearFlags),
    .oIP(oIP), .oDepth(oDepth), .oFull(oFull), .oEmpty(oEmpty),
    .oOverflow(oOverflow), .oUnderflow(oUnderflow)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("chk  %s: %0h", tag, got);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic step(input logic rst, input logic en, input logic ret, input logic call,
                      input logic br, input logic [15:0] tgt, input logic clr);
    @(negedge Clock);
    Reset = rst; iEnable = en; iRet = ret; iCall = call; iBranch = br;
    iTarget = tgt; iClearFlags = clr;
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    check_val("rst_ip", oIP, 16'h0000);
    check_val("rst_depth", oDepth, 0);
    check_val("rst_empty", oEmpty, 1);
    check_val("rst_full", oFull, 0);
    check_val("rst_ovf", oOverflow, 0);
    check_val("rst_unf", oUnderflow, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

    // Sequential fetch after release
    for (int i = 1; i <= 5; i++) begin
      idle();
      check_val($sformatf("seq_ip%0d", i), oIP, 16'(i));
    end
    check_val("seq_empty", oEmpty, 1);

    // CALL decoded the cycle after fetch at 5: return address is 6
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 1'b0);
    check_val("call_ip", oIP, 16'h0040);
    idle();
    check_val("call_ip_next", oIP, 16'h0041);
    check_val("call_depth", oDepth, 1);
    idle();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check_val("ret_ip", oIP, 16'h0006);
    idle();
    check_val("ret_ip_next", oIP, 16'h0007);
    check_val("ret_depth", oDepth, 0);

    // Three nested calls (rPC=8 at first), back-to-back returns
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0);
    check_val("nest_c1", oIP, 16'h0010);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 1'b0);
    check_val("nest_c2", oIP, 16'h0020);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0030, 1'b0);
    check_val("nest_c3", oIP, 16'h0030);
    idle();
    check_val("nest_ip", oIP, 16'h0031);
    check_val("nest_depth3", oDepth, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check_val("nest_r1", oIP, 16'h0021);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check_val("nest_r2", oIP, 16'h0011);
    check_val("nest_depth2", oDepth, 2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check_val("nest_r3", oIP, 16'h0008);
    idle();
    check_val("nest_after", oIP, 16'h0009);
    check_val("nest_depth0", oDepth, 0);

    // Nine nested calls: first push is rPC=0x000A, then target+1 of each call
    pushes[0] = 16'h000A;
    for (int i = 1; i < 9; i++) pushes[i] = 16'(16'h0100 + 16'h0010 * (i - 1) + 1);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'(16'h0100 + 16'h0010 * i), 1'b0);
`ifdef IPSEQ_TRAP_EN
      check_val($sformatf("ovf_call%0d", i), oIP, (i == 8) ? 16'hFFF0 : 16'(16'h0100 + 16'h0010 * i));
`else
      check_val($sformatf("ovf_call%0d", i), oIP, 16'(16'h0100 + 16'h0010 * i));
`endif
    end
    idle();
    check_val("ovf_depth", oDepth, 8);
    check_val("ovf_full", oFull, 1);
`ifdef IPSEQ_TRAP_EN
    check_val("ovf_ip", oIP, 16'hFFF1);
    check_val("ovf_flag", oOverflow, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check_val("ovf_flag_hold", oOverflow, 1);
    idle();
    check_val("ovf_flag_clr", oOverflow, 0);
`else
    check_val("ovf_ip", oIP, 16'h0181);
    check_val("ovf_flag_tied", oOverflow, 0);
`endif
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      check_val($sformatf("ovf_depth_r%0d", j), oDepth, 8 - j);
`ifdef IPSEQ_TRAP_EN
      check_val($sformatf("ovf_ret%0d", j), oIP, pushes[7 - j]);
`else
      check_val($sformatf("ovf_ret%0d", j), oIP, pushes[8 - j]);
`endif
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
`ifdef IPSEQ_TRAP_EN
    check_val("unf_ret_ip", oIP, 16'hFFF0);
    idle();
    check_val("unf_flag", oUnderflow, 1);
    check_val("unf_ip_next", oIP, 16'hFFF1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    idle();
    check_val("unf_flag_clr", oUnderflow, 0);
`else
    check_val("unf_ret_ip", oIP, 16'h0000);
    idle();
    check_val("unf_flag_tied", oUnderflow, 0);
    check_val("unf_ip_next", oIP, 16'h0001);
`endif
    check_val("unf_depth", oDepth, 0);
    check_val("unf_empty", oEmpty, 1);

    // Priority and stall
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b0);
    check_val("br_ip", oIP, 16'h0200);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0050, 1'b0);
    check_val("pri_call_ip", oIP, 16'h0050);
    idle();
    check_val("pri_depth1", oDepth, 1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0077, 1'b0);
    check_val("stall_ip", oIP, 16'h0052);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0077, 1'b0);
    check_val("stall_ip_hold", oIP, 16'h0052);
    check_val("stall_depth", oDepth, 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0077, 1'b0);
    check_val("pri_ret_ip", oIP, 16'h0201);
    idle();
    check_val("pri_ret_next", oIP, 16'h0202);
    check_val("pri_depth0", oDepth, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0300, 1'b0);
    check_val("pri_cb_ip", oIP, 16'h0300);
    idle();
    check_val("pri_cb_depth", oDepth, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check_val("pri_cb_ret", oIP, 16'h0203);

    // Reset in the middle of a call chain
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'(16'h0400 + 16'h0010 * i), 1'b0);
    idle();
    check_val("mid_depth4", oDepth, 4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    check_val("mid_rst_ip", oIP, 16'h0000);
    idle();
    check_val("mid_rst_depth", oDepth, 0);
    check_val("mid_rst_ip_next", oIP, 16'h0001);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
`ifdef IPSEQ_TRAP_EN
    check_val("mid_ret_ip", oIP, 16'hFFF0);
    idle();
    check_val("mid_unf", oUnderflow, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    idle();
    check_val("mid_unf_fault_wins", oUnderflow, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    idle();
    check_val("mid_unf_clr", oUnderflow, 0);
`else
    check_val("mid_ret_ip", oIP, 16'h0000);
    idle();
    check_val("mid_ret_next", oIP, 16'h0001);
`endif

    // Address wrap at the top of the space
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    check_val("wrap_fffe", oIP, 16'hFFFE);
    idle();
    check_val("wrap_ffff", oIP, 16'hFFFF);
    idle();
    check_val("wrap_0000", oIP, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
